// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, default baud divisor and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  // Parity over the low nbits of data; odd=1 inverts the result.
  function automatic logic par_calc(input logic [7:0] data, input int unsigned nbits,
                                    input logic odd);
    logic p;
    p = odd;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..TERMINAL and wraps, tick_o marks the last cycle of a bit.
module uart_baud_cnt #(
  parameter int unsigned TERMINAL = 433
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 16'(TERMINAL));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready byte intake, LSB-first frame with optional parity and 1-2 stops.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_o
);

  localparam logic [7:0] DataMask = 8'((16'd1 << DATA_BITS) - 16'd1);

  uart_tx_state_e state_q, state_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bit_q, bit_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           tick;
  logic           accept;
  logic           last_data;
  logic           last_stop;

  assign accept    = tx_valid_i && (state_q == IDLE);
  assign last_data = (bit_q == 3'(DATA_BITS - 1));
  assign last_stop = (bit_q == 3'(STOP_BITS - 1));

  uart_baud_cnt #(
    .TERMINAL (CLKS_PER_BIT - 1)
  ) u_baud_cnt (
    .clk    (clk),
    .rst_ni (rst_ni),
    .clr_i  (state_q == IDLE),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && last_data) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_d = STOP;
      STOP:    if (tick && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Parity is frozen at acceptance so it never depends on the shifting register.
  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    par_d   = par_q;
    if (accept) begin
      shreg_d = tx_data_i & DataMask;
      par_d   = par_calc(tx_data_i, DATA_BITS, PARITY_ODD != 0);
      bit_d   = '0;
    end else if (tick) begin
      if (state_q == DATA) begin
        shreg_d = shreg_q >> 1;
        bit_d   = last_data ? 3'd0 : bit_q + 3'd1;
      end else if (state_q == STOP) begin
        bit_d = last_stop ? 3'd0 : bit_q + 3'd1;
      end
    end
  end

  // The line level is decoded from next-state values so tx_o is a true flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = (state_q == IDLE);
  assign tx_busy_o  = (state_q != IDLE);
  assign tx_done_o  = (state_q == STOP) && tick && last_stop;

endmodule
